// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and sizing helper for the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int maxInt(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversample tick counter ending a bit period or an idle gap
module uart_bit_timer import uart_pkg::*; #(
  parameter int BIT_TICKS = 16,
  parameter int GAP_TICKS = 16
) (
  input  logic CLK288MHZ,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic gapMode,
  output logic bitEnd,
  output logic gapEnd
);
  localparam int W = $clog2(maxInt(BIT_TICKS, GAP_TICKS + 1));
  localparam logic [W-1:0] BIT_LAST = W'(BIT_TICKS - 1);
  localparam logic [W-1:0] GAP_LAST = W'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);
  logic [W-1:0] tickCnt;
  logic atEnd;
  assign atEnd  = tick && tickCnt == (gapMode ? GAP_LAST : BIT_LAST);
  assign bitEnd = atEnd && !gapMode;
  assign gapEnd = atEnd && gapMode;
  // clear wins over a coincident tick so a new frame starts from a full period
  always_ff @(posedge CLK288MHZ)
    if (reset || clear || atEnd) tickCnt <= '0;
    else if (tick) tickCnt <= tickCnt + 1'b1;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter fed by a show-ahead FIFO
// Optional UART_TX_CTS_EN adds a synchronised active-low clear-to-send input gating frame starts.
module uart_tx_param import uart_pkg::*; #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int GAP_TICKS   = 16
) (
  input  logic                 CLK288MHZ,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] dataIn,
  input  logic                 fifoNE,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  output logic                 readEn,
  output logic                 uart_txd_in,
  output logic                 busy,
  output logic                 frame_done
);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 2 || GAP_TICKS < 0) begin : g_badParams
    $error("uart_tx_param: illegal parameter set");
  end
  state_t state, nState;
  logic [DATA_BITS-1:0] shiftReg, nShift;
  logic [3:0] bitCnt, nBitCnt;
  logic par, nPar, nTxd, nReadEn, nFrameDone;
  logic bitEnd, gapEnd, startOk, lastStop, exitPt, capture;
`ifdef UART_TX_CTS_EN
  logic [1:0] ctsSync;
  always_ff @(posedge CLK288MHZ)
    ctsSync <= reset ? 2'b11 : {ctsSync[0], cts_n};
  assign startOk = fifoNE && !ctsSync[1];
`else
  assign startOk = fifoNE;
`endif
  uart_bit_timer #(.BIT_TICKS(OVERSAMPLE), .GAP_TICKS(GAP_TICKS)) u_timer (
    .CLK288MHZ(CLK288MHZ),
    .reset(reset),
    .tick(tick),
    .clear(capture || state == IDLE),
    .gapMode(state == GAP),
    .bitEnd(bitEnd),
    .gapEnd(gapEnd)
  );
  assign lastStop = bitCnt == 4'(STOP_BITS - 1);
  // every point where a new word may be taken: idle, gap expiry, or stop end with no gap
  assign exitPt  = state == IDLE || (state == GAP && gapEnd) ||
                   (GAP_TICKS == 0 && state == STOP && bitEnd && lastStop);
  assign capture = exitPt && startOk;
  always_comb begin
    nState     = state;
    nShift     = shiftReg;
    nBitCnt    = bitCnt;
    nPar       = par;
    nTxd       = uart_txd_in;
    nFrameDone = 1'b0;
    case (state)
      START: if (bitEnd) begin
        nState  = DATA;
        nTxd    = shiftReg[0];
        nPar    = shiftReg[0];
        nBitCnt = '0;
      end
      DATA: if (bitEnd) begin
        if (bitCnt < 4'(DATA_BITS - 1)) begin
          nShift  = shiftReg >> 1;
          nTxd    = shiftReg[1];
          nPar    = par ^ shiftReg[1];
          nBitCnt = bitCnt + 4'd1;
        end else if (PARITY_MODE != PAR_NONE) begin
          nState = PARITY;
          nTxd   = PARITY_MODE == PAR_ODD ? ~par : par;
        end else begin
          nState  = STOP;
          nTxd    = 1'b1;
          nBitCnt = '0;
        end
      end
      PARITY: if (bitEnd) begin
        nState  = STOP;
        nTxd    = 1'b1;
        nBitCnt = '0;
      end
      STOP: if (bitEnd) begin
        nFrameDone = lastStop;
        nBitCnt    = lastStop ? '0 : bitCnt + 4'd1;
        nState     = lastStop ? GAP : STOP;
      end
      default: ;
    endcase
    if (exitPt) begin
      nState = capture ? START : IDLE;
      nTxd   = !capture;
    end
    if (capture) nShift = dataIn;
    nReadEn = capture;
  end
  always_ff @(posedge CLK288MHZ)
    if (reset) begin
      state       <= IDLE;
      shiftReg    <= '0;
      bitCnt      <= '0;
      par         <= 1'b0;
      uart_txd_in <= 1'b1;
      readEn      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= nState;
      shiftReg    <= nShift;
      bitCnt      <= nBitCnt;
      par         <= nPar;
      uart_txd_in <= nTxd;
      readEn      <= nReadEn;
      busy        <= nState != IDLE;
      frame_done  <= nFrameDone;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed table-driven bench for uart_tx_param over three parameter sets
module tb_uart_tx_param;
  typedef struct {
    logic [7:0] d;
    logic       p;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic ne [3];
  logic txd [3];
  logic busy [3];
  logic re [3];
  logic fd [3];
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [1:0] ph = 2'd0;
  logic tick2 = 1'b0;
  int pops [3] = '{0, 0, 0};
  int checks = 0;
  int errors = 0;
  int rel = 0;
  vec_t tbl [6];
`ifdef UART_TX_CTS_EN
  logic cts_n;
  localparam int RLAT = 3;
`else
  localparam int RLAT = 1;
`endif

  uart_tx_param u0 (
    .CLK288MHZ(clk), .reset(reset), .tick(1'b1), .dataIn(d0), .fifoNE(ne[0]),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .readEn(re[0]), .uart_txd_in(txd[0]), .busy(busy[0]), .frame_done(fd[0]));

  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
    .CLK288MHZ(clk), .reset(reset), .tick(1'b1), .dataIn(d1), .fifoNE(ne[1]),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .readEn(re[1]), .uart_txd_in(txd[1]), .busy(busy[1]), .frame_done(fd[1]));

  uart_tx_param #(.OVERSAMPLE(8), .GAP_TICKS(0)) u2 (
    .CLK288MHZ(clk), .reset(reset), .tick(tick2), .dataIn(d2), .fifoNE(ne[2]),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .readEn(re[2]), .uart_txd_in(txd[2]), .busy(busy[2]), .frame_done(fd[2]));

  always @(negedge clk) begin
    ph    <= ph + 2'd1;
    tick2 <= ph == 2'd3;
  end

  always @(negedge clk)
    for (int s = 0; s < 3; s++) if (re[s] === 1'b1) pops[s]++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic adv(input int k);
    repeat (k - rel) @(posedge clk);
    rel = k;
    #1;
  endtask

  // lat = edges until the capture edge (0: capture already happened at the current edge)
  task automatic frame(input int s, input logic [15:0] exp, input int nb, input int bc,
                       input int gc, input int lat, input bit keep, input logic [7:0] nd);
    int p0;
    p0 = pops[s];
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      #1;
      if (i < lat) chk($sformatf("u%0d early readEn", s), int'(re[s]), 0);
    end
    chk($sformatf("u%0d capture readEn", s), int'(re[s]), 1);
    chk($sformatf("u%0d capture busy", s), int'(busy[s]), 1);
    if (!keep) ne[s] = 1'b0;
    if (s == 0) d0 = nd;
    else if (s == 1) d1 = nd[6:0];
    else d2 = nd;
    rel = 0;
    for (int j = 0; j < nb; j++) begin
      adv(j * bc + bc / 2);
      chk($sformatf("u%0d bit%0d", s, j), int'(txd[s]), int'(exp[j]));
    end
    adv(nb * bc - 1);
    chk($sformatf("u%0d frame_done early", s), int'(fd[s]), 0);
    chk($sformatf("u%0d busy late", s), int'(busy[s]), 1);
    adv(nb * bc);
    chk($sformatf("u%0d frame_done", s), int'(fd[s]), 1);
    if (gc > 0) begin
      adv(nb * bc + 1);
      chk($sformatf("u%0d frame_done width", s), int'(fd[s]), 0);
      adv(nb * bc + gc - 1);
      chk($sformatf("u%0d gap busy", s), int'(busy[s]), 1);
      chk($sformatf("u%0d gap line", s), int'(txd[s]), 1);
      adv(nb * bc + gc);
    end
    chk($sformatf("u%0d end readEn", s), int'(re[s]), keep ? 1 : 0);
    chk($sformatf("u%0d end line", s), int'(txd[s]), keep ? 0 : 1);
    chk($sformatf("u%0d end busy", s), int'(busy[s]), keep ? 1 : 0);
    chk($sformatf("u%0d pops per frame", s), pops[s] - p0, 1);
  endtask

  initial begin
    int p;
    tbl[0] = '{8'hA5, 1'b1};
    tbl[1] = '{8'h00, 1'b1};
    tbl[2] = '{8'hFF, 1'b1};
    tbl[3] = '{8'h01, 1'b0};
    tbl[4] = '{8'h3C, 1'b1};
    tbl[5] = '{8'h7F, 1'b0};
    reset = 1'b1;
    for (int s = 0; s < 3; s++) ne[s] = 1'b0;
    d0 = '0;
    d1 = '0;
    d2 = '0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("u%0d reset line", s), int'(txd[s]), 1);
      chk($sformatf("u%0d reset busy", s), int'(busy[s]), 0);
      chk($sformatf("u%0d reset readEn", s), int'(re[s]), 0);
      chk($sformatf("u%0d reset frame_done", s), int'(fd[s]), 0);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // single words, default configuration, odd parity
    for (int i = 0; i < 6; i++) begin
      ne[0] = 1'b1;
      d0 = tbl[i].d;
      frame(0, {5'b0, 1'b1, tbl[i].p, tbl[i].d, 1'b0}, 11, 16, 16, 1, 1'b0, tbl[i].d);
      repeat (2) @(posedge clk);
      #1;
    end
    // 7 data bits, even parity, two stop bits
    ne[1] = 1'b1;
    d1 = 7'h07;
    frame(1, 16'b11100001110, 11, 16, 16, 1, 1'b0, 8'h07);
    // back-to-back frames straight from GAP into START
    ne[0] = 1'b1;
    d0 = 8'h00;
    frame(0, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 16, 16, 1, 1'b1, 8'hFF);
    frame(0, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 16, 16, 0, 1'b0, 8'hFF);
    // sparse ticks, no gap: restart right on the stop-bit end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (tick2) break;
    end
    d2 = 8'h81;
    ne[2] = 1'b1;
    frame(2, {5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 32, 0, 1, 1'b1, 8'h01);
    frame(2, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 32, 0, 0, 1'b0, 8'h01);
    // reset in the middle of data bit 3
    repeat (2) @(posedge clk);
    #1;
    ne[0] = 1'b1;
    d0 = 8'h3C;
    @(posedge clk);
    #1;
    chk("rst capture readEn", int'(re[0]), 1);
    rel = 0;
    adv(70);
    chk("rst data bit3", int'(txd[0]), 1);
    chk("rst busy before", int'(busy[0]), 1);
    p = pops[0];
    reset = 1'b1;
    d0 = 8'h5A;
    adv(71);
    chk("rst line", int'(txd[0]), 1);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst readEn", int'(re[0]), 0);
    chk("rst frame_done", int'(fd[0]), 0);
    chk("rst no pop", pops[0] - p, 0);
    reset = 1'b0;
    frame(0, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, 16, 16, RLAT, 1'b0, 8'h5A);
`ifdef UART_TX_CTS_EN
    // clear-to-send holds off the frame until it has crossed the synchroniser
    cts_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    p = pops[0];
    ne[0] = 1'b1;
    d0 = 8'hA5;
    repeat (10) @(posedge clk);
    #1;
    chk("cts held pops", pops[0] - p, 0);
    chk("cts held line", int'(txd[0]), 1);
    chk("cts held busy", int'(busy[0]), 0);
    cts_n = 1'b0;
    frame(0, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 16, 16, 3, 1'b0, 8'hA5);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter for the 288 MHz domain. It pulls bytes from the speculative FIFO (show-ahead: dataIn is valid whenever fifoNE is high) and serialises them LSB-first on uart_txd_in. Bit timing uses the oversampling tick from the shared baud generator. Over the current transmitter it adds configurable data width, parity mode, stop-bit count, inter-frame gap, back-to-back framing and status outputs.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 2, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
OVERSAMPLE, 16, tick pulses per bit period; must be at least 2.
GAP_TICKS, 16, extra idle-high ticks after the stop bits, for fifoNE settling; 0 is legal.

Ports:
CLK288MHZ  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
tick  input  1  one-cycle baud-oversample strobe.
dataIn  input  DATA_BITS  FIFO head word; valid while fifoNE is high.
fifoNE  input  1  FIFO not empty.
readEn  output  1  one-cycle FIFO pop strobe.
uart_txd_in  output  1  serial line; idles high.
busy  output  1  high while any state other than IDLE is active.
frame_done  output  1  one-cycle pulse on the cycle the last stop bit completes.

Behaviour:
- Reset values: uart_txd_in = 1, readEn = 0, busy = 0, frame_done = 0, state = IDLE, all counters = 0.
- All outputs are registered.
- Reset has priority at any point, including mid-frame. On the edge where reset is sampled high, the line returns high and no pop is issued; the interrupted word is dropped.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- Bit timer: tick_cnt increments on each tick. "bit_end" is defined as tick && tick_cnt == OVERSAMPLE-1. At bit_end, tick_cnt clears to 0. Cycles without tick hold all counters.
- IDLE:
  - uart_txd_in = 1.
  - If fifoNE is high at edge n: at edge n+1, shift_reg <= dataIn, readEn = 1 for exactly one cycle, state = START, uart_txd_in = 0, tick_cnt = 0.
- START: line held low. At bit_end go to DATA, drive shift_reg[0], and set bit_cnt = 0.
- DATA:
  - Bits are driven LSB first. At bit_end, if bit_cnt < DATA_BITS-1, increment bit_cnt and drive the next bit.
  - Otherwise, go to PARITY if PARITY_MODE != 0, else go to STOP.
- Parity: a running XOR over the data bits is accumulated as they are driven. The PARITY bit equals the XOR for even parity and its inverse for odd parity. It lasts one bit period; at bit_end go to STOP.
- STOP: line high for STOP_BITS bit periods. At the final bit_end, pulse frame_done and go to GAP; if GAP_TICKS == 0, go to the GAP exit decision immediately.
- GAP: line high for GAP_TICKS ticks. At exit:
  - If fifoNE is high, capture and pop as in IDLE and go straight to START (back-to-back framing, no IDLE cycle).
  - Otherwise go to IDLE.
- readEn is never asserted outside an IDLE-to-START or GAP-to-START transition.
- readEn is never asserted twice per frame.
- fifoNE may drop while a frame is in flight; this has no effect on the frame.
- A tick coinciding with the capture edge is not counted toward the START bit, so START lasts a full OVERSAMPLE ticks after capture.
- Frame length in ticks: OVERSAMPLE × (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) + GAP_TICKS.
- Widths:
  - tick_cnt is sized as $clog2(max(OVERSAMPLE, GAP_TICKS + 1)).
  - bit_cnt is 4 bits.
  - Counters never wrap in legal configurations.
- Illegal parameter values are rejected by an elaboration-time check.

Optional Feature:
UART_TX_CTS_EN
- Defined: adds input cts_n (active-low clear-to-send, 2-flop synchronised internally). A new frame, whether from IDLE or from the GAP exit, starts only when fifoNE is high and the synchronised cts_n is 0. A deassertion of cts_n mid-frame does not stop the frame; the word completes normally.
- Undefined: the cts_n port and synchroniser are absent, and frame start depends on fifoNE alone.

Decomposition:
- Package uart_pkg:
  - state encoding localparams: IDLE = 3'd0, START = 1, DATA = 2, PARITY = 3, STOP = 4, GAP = 5;
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
- Sub-module uart_bit_timer: tick counter with programmable terminal count and a clear input. Outputs bit_end and gap_end. It is reusable by the future parametrised receiver.

Test Plan:
1. Default parameters, tick tied high, fifoNE = 1 for one word 8'hA5:
   - readEn pulses exactly once, one cycle after fifoNE rises.
   - Line sequence (16 cycles each): 0, 1,0,1,0,0,1,0,1, parity 1, stop 1.
   - frame_done pulses at cycle 176; busy falls at cycle 192.
2. PARITY_MODE = 1, DATA_BITS = 7, STOP_BITS = 2, word 7'h07:
   - Even parity bit = 1, two stop bits.
   - Total frame = 16 × 11 ticks, then GAP_TICKS.
3. Back-to-back: fifoNE held high with words 8'h00 then 8'hFF:
   - Second start bit begins the cycle after GAP ends, with no IDLE cycle.
   - Odd parity bits are 1 then 1.
   - Exactly two readEn pulses.
4. tick every 4th cycle, OVERSAMPLE = 8, GAP_TICKS = 0:
   - Each bit lasts 32 cycles.
   - frame_done is followed by an immediate restart when fifoNE is high.
5. Reset asserted during DATA bit 3:
   - Next edge: uart_txd_in = 1, busy = 0, no readEn pulse.
   - After release with fifoNE = 1, a fresh frame starts with the current dataIn.
6. UART_TX_CTS_EN defined, cts_n = 1, fifoNE = 1:
   - No readEn and the line stays high.
   - Drop cts_n to 0: readEn pulses 3 cycles later (2-flop synchroniser plus capture) and the frame proceeds.
